// File: rtl/mult_unit.sv
// 32x32 -> 64 sequential shift-add multiplier with a level-held start and a pause on multControl low.
// Define MULT_SIGNED_EN to add signed (MULT) support via magnitude capture and a final SIGN negation state.
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        multControl,
    input  logic        signedOp,
    input  logic [31:0] aInput,
    input  logic [31:0] bInput,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        ok
);

`ifdef MULT_SIGNED_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mcand_q, mcand_d;
    logic [4:0]  count_q, count_d;
    logic [32:0] sum;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

`ifdef MULT_SIGNED_EN
    logic        sign_q, sign_d;
    logic        start_sign;

    // Signed operands are multiplied as magnitudes; 0x80000000 maps to 2^31 unsigned.
    always_comb begin
        a_mag      = (signedOp && aInput[31]) ? (32'd0 - aInput) : aInput;
        b_mag      = (signedOp && bInput[31]) ? (32'd0 - bInput) : bInput;
        start_sign = signedOp & (aInput[31] ^ bInput[31]);
    end
`else
    logic        unused_signed_op;
    assign unused_signed_op = signedOp;

    always_comb begin
        a_mag = aInput;
        b_mag = bInput;
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            mcand_q <= 32'd0;
            count_q <= 5'd0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
`ifdef MULT_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (multControl) state_d = S_RUN;
            end
            S_RUN: begin
                if (multControl && (count_q == 5'd0)) begin
`ifdef MULT_SIGNED_EN
                    state_d = S_SIGN;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            S_SIGN: begin
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (!multControl) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        count_d = count_q;
        sum     = 33'd0;
`ifdef MULT_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (multControl) begin
                    mcand_d = a_mag;
                    hi_d    = 32'd0;
                    lo_d    = b_mag;
                    count_d = 5'd31;
`ifdef MULT_SIGNED_EN
                    sign_d  = start_sign;
`endif
                end
            end
            S_RUN: begin
                if (multControl) begin
                    // Carry out of the add shifts into HI[31]; the dropped LO bit is the consumed multiplier bit.
                    sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
                    hi_d    = sum[32:1];
                    lo_d    = {sum[0], lo_q[31:1]};
                    count_d = count_q - 5'd1;
                end
            end
`ifdef MULT_SIGNED_EN
            S_SIGN: begin
                if (sign_q) {hi_d, lo_d} = 64'd0 - {hi_q, lo_q};
            end
`endif
            default: begin
            end
        endcase
    end

    // Output logic
    always_comb begin
        ok = (state_q == S_IDLE) || (state_q == S_DONE);
        HI = hi_q;
        LO = lo_q;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Ports SHALL be exactly these, one per line (name, direction, width, meaning):
  clk          input   1   clock; all state changes on rising edge
  reset        input   1   synchronous active-high reset
  multControl  input   1   start request; level, held by controller for whole operation
  signedOp     input   1   1 = signed (MULT), 0 = unsigned (MULTU); sampled at start
  aInput       input   32  multiplicand
  bInput       input   32  multiplier
  HI           output  32  product bits [63:32]
  LO           output  32  product bits [31:0]
  ok           output  1   1 = idle or result valid; 0 = operation in progress
REQ-003 SHALL have no parameters; width fixed at 32x32->64.

Function
REQ-004 SHALL implement states IDLE, RUN, SIGN, DONE (SIGN exists only with MULT_SIGNED_EN).
REQ-005 IDLE: ok=1; multControl=1 at an edge SHALL capture aInput, bInput, signedOp, set HI=0, LO=multiplier operand, count=31, go RUN.
REQ-006 RUN: ok=0; each edge with multControl=1 SHALL do one shift-add step: if LO[0], {c,HI}=HI+multiplicand (33-bit), else {c,HI}={0,HI}; then {c,HI,LO} shifted right by 1; count decrements.
REQ-007 RUN with multControl=0 SHALL pause: all state held, ok stays 0; resumes when multControl returns to 1.
REQ-008 Step at count=0 SHALL exit RUN to SIGN (macro defined) or DONE (macro undefined).
REQ-009 Latency with multControl held: ok=1 and valid HI/LO on the 33rd edge after the start edge (34th with MULT_SIGNED_EN); each paused cycle adds one.
REQ-010 DONE: ok=1, HI/LO hold full 64-bit product; SHALL remain DONE while multControl=1 (no auto-restart); multControl=0 SHALL go IDLE with HI/LO held.
REQ-011 New operation SHALL start only from IDLE; controller must drop multControl for >=1 cycle between operations.
REQ-012 aInput/bInput/signedOp changes after the start edge SHALL have no effect on the current operation.
REQ-013 HI/LO during RUN/SIGN are intermediate and SHALL NOT be relied upon; ok=0 marks them invalid.
REQ-014 Zero operand, all-ones operands, 0x80000000 operands SHALL produce exact 64-bit results; no overflow or error output exists.

Reset
REQ-015 reset=1 at an edge SHALL force IDLE, HI=0, LO=0, ok=1, count=0, captured operands=0, overriding multControl.
REQ-016 reset mid-operation (RUN or SIGN) SHALL abort; no partial result retained; next start behaves as from power-up.

Configuration
REQ-017 Macro MULT_SIGNED_EN SHALL select signed support.
REQ-018 Defined: at start, if signedOp=1, operands replaced by absolute values (0x80000000 -> magnitude 2^31 unsigned) and result sign = aInput[31] XOR bInput[31]; SIGN state (one cycle, ok=0) negates {HI,LO} in two's complement when sign=1, else passes through; then DONE. signedOp=0 computes unsigned, still passing through SIGN.
REQ-019 Undefined: signedOp ignored, all operations unsigned, no SIGN state, no magnitude/negation logic synthesized.

Verification
REQ-020 Unsigned: a=7, b=6, multControl held -> ok=0 for 32 cycles, ok=1 on edge 33 (34 signed build), HI=0x00000000, LO=0x0000002A.
REQ-021 Unsigned max: a=b=0xFFFFFFFF, signedOp=0 -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-022 Signed (MULT_SIGNED_EN): a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; a=0x80000000, b=1 -> HI=0xFFFFFFFF, LO=0x80000000; undefined build same -3x5 -> HI=0x00000004, LO=0xFFFFFFF1.
REQ-023 Pause: a=3, b=4, multControl low 5 cycles mid-RUN -> ok rises 5 cycles later than REQ-020, LO=0x0000000C.
REQ-024 Hold/restart: multControl held 10 cycles in DONE -> HI/LO unchanged, ok=1; drop 1 cycle, new operands a=2, b=2 -> LO=0x00000004.
REQ-025 Reset mid-op: reset at 10th RUN cycle -> next edge ok=1, HI=0, LO=0, IDLE; following start a=5, b=5 -> LO=0x00000019.
